// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: imem request/response, branch redirect and decode handshake bundle.
interface if_fetch_queue_if #(
  parameter int PC_WIDTH = 64
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_rdata;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                id_valid;
  logic                id_ready;
  logic [31:0]         id_instr;
  logic [PC_WIDTH-1:0] id_pc;
  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: LEGv8 fetch stage issuing 1-cycle imem reads into a small instruction queue for decode.
module if_fetch_queue #(
  parameter int                  PC_WIDTH    = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  QUEUE_DEPTH = 2
) (
  input logic CLK,
  input logic RESETn,
  if_fetch_queue_if.master bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(QUEUE_DEPTH - 1);
  localparam logic [CW:0] DEPTH = (CW + 1)'(QUEUE_DEPTH);
  logic [PC_WIDTH-1:0] pc, req_pc;
  logic                inflight;
  logic [31:0]         q_instr [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
  logic [AW-1:0]       head, tail;
  logic [CW-1:0]       count;
  logic [CW:0]         occ;
  logic                pop, issue;
  // An outstanding request reserves its slot, so the queue can never overflow.
  always_comb begin
    occ   = {1'b0, count} + (CW + 1)'(inflight);
    pop   = (count != '0) && bus.id_ready;
    issue = !bus.redirect_valid && (occ < DEPTH || (occ == DEPTH && pop));
  end
  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;
  assign bus.id_valid  = count != '0;
  assign bus.id_instr  = q_instr[head];
  assign bus.id_pc     = q_pc[head];
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (bus.redirect_valid) begin
      pc       <= {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc     <= pc + PC_WIDTH'(4);
        req_pc <= pc;
      end
      if (inflight) begin
        q_instr[tail] <= bus.imem_rdata;
        q_pc[tail]    <= req_pc;
        tail          <= tail == LAST ? '0 : tail + 1'b1;
      end
      if (pop) head <= head == LAST ? '0 : head + 1'b1;
      count <= count + CW'(inflight) - CW'(pop);
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed stimulus with a queue-based fetch model checked every cycle, plus literal pins.
module tb_if_fetch_queue;
  localparam int D = 2;
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  if_fetch_queue_if bus ();
  if_fetch_queue dut (.CLK(clk), .RESETn(rst_n), .bus(bus));
  ent_t        mq[$];
  logic [63:0] m_pc, m_req_pc;
  logic        m_infl;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        lvalid, lreq;
  logic [31:0] linstr;
  logic [63:0] lpc, laddr;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic m_pop();
    return mq.size() != 0 && bus.id_ready;
  endfunction
  function automatic logic m_issue();
    int occ;
    occ = mq.size() + int'(m_infl);
    return !bus.redirect_valid && (occ < D || (occ == D && m_pop()));
  endfunction
  task automatic model_reset();
    mq.delete();
    m_pc = 64'h0;
    m_req_pc = 64'h0;
    m_infl = 1'b0;
  endtask
  task automatic model_edge();
    logic p, is;
    ent_t e;
    p  = m_pop();
    is = m_issue();
    if (bus.redirect_valid) begin
      mq.delete();
      m_pc = {bus.redirect_pc[63:2], 2'b00};
      m_infl = 1'b0;
    end else begin
      if (p) e = mq.pop_front();
      if (m_infl) begin
        e.instr = bus.imem_rdata;
        e.pc = m_req_pc;
        mq.push_back(e);
      end
      if (is) begin
        m_req_pc = m_pc;
        m_pc = m_pc + 64'd4;
      end
      m_infl = is;
    end
  endtask
  // Memory returns the low word of the requested address one cycle later.
  task automatic step(input logic rv, input logic [63:0] rpc, input logic rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    bus.id_ready = rdy;
    @(negedge clk);
    lvalid = bus.id_valid;
    lreq = bus.imem_req;
    linstr = bus.id_instr;
    lpc = bus.id_pc;
    laddr = bus.imem_addr;
    @(posedge clk);
    model_edge();
    #1 bus.imem_rdata = lreq ? laddr[31:0] : 32'hDEAD_BEEF;
  endtask
  always @(negedge clk)
    if (rst_n) begin
      check("imem_req", 64'(bus.imem_req), 64'(m_issue()));
      check("imem_addr", bus.imem_addr, m_pc);
      check("id_valid", 64'(bus.id_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("id_instr", 64'(bus.id_instr), 64'(mq[0].instr));
        check("id_pc", bus.id_pc, mq[0].pc);
      end
      check("count_bound", 64'(dut.count <= 2'd2), 64'd1);
    end
  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 64'h0;
    bus.id_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    model_reset();
    #12;
    check("rst_valid", 64'(bus.id_valid), 64'd0);
    check("rst_instr", 64'(bus.id_instr), 64'd0);
    check("rst_pc", bus.id_pc, 64'd0);
    check("rst_addr", bus.imem_addr, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 64'h0, 1'b1);
    check("t1_req0", 64'(lreq), 64'd1);
    check("t1_addr0", laddr, 64'h0);
    check("t1_valid0", 64'(lvalid), 64'd0);
    step(1'b0, 64'h0, 1'b1);
    check("t1_addr1", laddr, 64'h4);
    check("t1_valid1", 64'(lvalid), 64'd0);
    step(1'b0, 64'h0, 1'b1);
    check("t1_valid2", 64'(lvalid), 64'd1);
    check("t1_pc2", lpc, 64'h0);
    check("t1_addr2", laddr, 64'h8);
    step(1'b0, 64'h0, 1'b1);
    check("t1_pc3", lpc, 64'h4);
    check("t1_instr3", 64'(linstr), 64'h4);
    step(1'b0, 64'h0, 1'b1);
    check("t1_pc4", lpc, 64'h8);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid", 64'(bus.id_valid), 64'd0);
    check("arst_addr", bus.imem_addr, 64'h0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 64'h0, 1'b0);
    check("bp_req", 64'(lreq), 64'd0);
    check("bp_addr", laddr, 64'h8);
    check("bp_valid", 64'(lvalid), 64'd1);
    check("bp_pc", lpc, 64'h0);
    step(1'b1, 64'h1003, 1'b0);
    check("rd1_req", 64'(lreq), 64'd0);
    step(1'b0, 64'h0, 1'b1);
    check("rd1_valid", 64'(lvalid), 64'd0);
    check("rd1_addr", laddr, 64'h1000);
    check("rd1_req1", 64'(lreq), 64'd1);
    step(1'b0, 64'h0, 1'b1);
    step(1'b0, 64'h0, 1'b1);
    check("rd1_pc", lpc, 64'h1000);
    check("rd1_instr", 64'(linstr), 64'h1000);
    step(1'b0, 64'h0, 1'b1);
    check("rd1_pc1", lpc, 64'h1004);
    step(1'b1, 64'h2000, 1'b1);
    check("rd2_popvalid", 64'(lvalid), 64'd1);
    check("rd2_req", 64'(lreq), 64'd0);
    step(1'b0, 64'h0, 1'b1);
    check("rd2_valid", 64'(lvalid), 64'd0);
    check("rd2_addr", laddr, 64'h2000);
    step(1'b0, 64'h0, 1'b1);
    step(1'b0, 64'h0, 1'b1);
    check("rd2_pc", lpc, 64'h2000);
    step(1'b0, 64'h0, 1'b1);
    check("rd2_pc1", lpc, 64'h2004);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    step(1'b0, 64'h0, 1'b1);
    check("wrap_addr0", laddr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 64'h0, 1'b1);
    check("wrap_addr1", laddr, 64'h0);
    step(1'b0, 64'h0, 1'b1);
    check("wrap_pc0", lpc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_instr0", 64'(linstr), 64'hFFFF_FFFC);
    step(1'b0, 64'h0, 1'b1);
    check("wrap_pc1", lpc, 64'h0);
    for (int i = 0; i < 24; i++) step(1'b0, 64'h0, (i % 3) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
